t04_timeout_counter_bank: RTL and testbench

Parametrised bank of independent elapsed-time / timeout counters for the team 04 screen and UI logic. Each channel starts on a synchronous start pulse, counts clock cycles, and clears on the rising edge of an asynchronous acknowledge, which is synchronised internally. Channels also detect a programmable threshold, in one-shot or periodic mode, and saturate at all-ones. One instance serves every screen-timeout, debounce-window and blink-period need in the design.

---
 rtl/t04_timeout_counter_bank.sv | 104 ++++++++++
 tb/tb_t04_timeout_counter_bank.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/t04_timeout_counter_bank.sv
// Bank of independent elapsed-time / timeout counters with synchronised async ack clear.
// Count updates one cycle after start; ack clears SYNC_STAGES+1 edges after sampling; no backpressure.
module t04_timeout_counter_bank #(
    parameter int WIDTH       = 23,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       ack,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] thresh,
    output logic [CHANNELS*WIDTH-1:0] ct,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       timeout,
    output logic [CHANNELS-1:0]       timeout_pulse,
    output logic [CHANNELS-1:0]       saturated,
    output logic                      any_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   ack_q;
        logic                   ack_edge;
        state_t                 state;
        state_t                 state_nxt;
        logic [WIDTH-1:0]       cnt;
        logic [WIDTH-1:0]       cnt_nxt;
        logic [WIDTH-1:0]       th;
        logic                   pulse;
        logic                   pulse_nxt;

        assign th = thresh[i*WIDTH +: WIDTH];

        // ack is asynchronous: resynchronise, then keep one extra flop to find the rising edge
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
                ack_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], ack[i]};
                ack_q  <= sync_q[SYNC_STAGES-1];
            end
        end

        assign ack_edge = sync_q[SYNC_STAGES-1] & ~ack_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= ST_IDLE;
                cnt   <= '0;
                pulse <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                pulse <= pulse_nxt;
            end
        end

        // start beats ack beats threshold; an ack edge coinciding with start is dropped
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            pulse_nxt = 1'b0;
            if (start[i]) begin
                state_nxt = ST_RUN;
                cnt_nxt   = ONE;
            end else if (ack_edge && state != ST_IDLE) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else if (state == ST_RUN) begin
                if (th != '0 && cnt == th) begin
                    pulse_nxt = 1'b1;
                    if (mode[i]) begin
                        cnt_nxt = ONE;
                    end else begin
                        state_nxt = ST_EXPIRED;
                    end
                end else if (cnt != ONES) begin
                    cnt_nxt = cnt + ONE;
                end
            end
        end

        assign ct[i*WIDTH +: WIDTH] = cnt;
        assign running[i]           = (state == ST_RUN);
        assign timeout[i]           = (state == ST_EXPIRED);
        assign timeout_pulse[i]     = pulse;
        assign saturated[i]         = (cnt == ONES);
    end

    assign any_timeout = |timeout;

endmodule

// File: tb/tb_t04_timeout_counter_bank.sv
// Directed bench for the timeout counter bank: default 23-bit x4 instance plus a 4-bit x1 instance.
module tb_t04_timeout_counter_bank;

    localparam int W  = 23;
    localparam int CH = 4;

    logic            clk;
    logic            rst;
    logic [CH-1:0]   start, ack, mode;
    logic [CH*W-1:0] thresh;
    logic [CH*W-1:0] ct;
    logic [CH-1:0]   running, timeout, timeout_pulse, saturated;
    logic            any_timeout;

    logic            s4, a4, m4;
    logic [3:0]      th4, ct4;
    logic            run4, to4, tp4, sat4, any4;

    int n_checks = 0;
    int n_pass   = 0;

    t04_timeout_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .mode(mode), .thresh(thresh),
        .ct(ct), .running(running), .timeout(timeout), .timeout_pulse(timeout_pulse),
        .saturated(saturated), .any_timeout(any_timeout)
    );

    t04_timeout_counter_bank #(.WIDTH(4), .CHANNELS(1), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .ack(a4), .mode(m4), .thresh(th4),
        .ct(ct4), .running(run4), .timeout(to4), .timeout_pulse(tp4),
        .saturated(sat4), .any_timeout(any4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // outputs are sampled, and inputs changed, on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] ctc(input int ch);
        return ct[ch*W +: W];
    endfunction

    initial begin
        int exp_ct[7];
        int exp_tp[7];
        rst = 1'b1; start = '0; ack = '0; mode = '0; thresh = '0;
        s4 = 1'b0; a4 = 1'b0; m4 = 1'b0; th4 = '0;
        #1;
        check("rst_ct_nonzero", {31'd0, ct != '0}, 0);
        check("rst_running", running, 0);
        check("rst_timeout", timeout, 0);
        check("rst_pulse", timeout_pulse, 0);
        check("rst_any", any_timeout, 0);
        step(); step();
        rst = 1'b0;
        step();
        check("idle_no_start", ctc(0), 0);

        // ch0 as a pure elapsed counter
        start[0] = 1'b1; step(); start[0] = 1'b0;
        check("ch0_ct1", ctc(0), 1);
        check("ch0_running", running[0], 1);
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("ch0_ct%0d", k), ctc(0), k);
        end
        check("others_running", running[3:1], 0);
        check("ch1_idle_ct", ctc(1), 0);

        // ch1 one-shot at 5, then ack clear
        thresh[1*W +: W] = 5;
        start[1] = 1'b1; step(); start[1] = 1'b0;
        check("ch1_ct1", ctc(1), 1);
        repeat (3) step();
        step();
        check("ch1_ct5", ctc(1), 5);
        check("ch1_not_expired", timeout[1], 0);
        step();
        check("ch1_expired", timeout[1], 1);
        check("ch1_pulse", timeout_pulse[1], 1);
        check("ch1_hold5", ctc(1), 5);
        check("ch1_stopped", running[1], 0);
        step();
        check("ch1_pulse_fall", timeout_pulse[1], 0);
        check("ch1_still5", ctc(1), 5);
        check("any_timeout", any_timeout, 1);
        ack[1] = 1'b1;
        step();
        check("ack_A_ct", ctc(1), 5);
        step();
        check("ack_A1_ct", ctc(1), 5);
        check("ack_A1_expired", timeout[1], 1);
        step();
        check("ack_cleared_ct", ctc(1), 0);
        check("ack_cleared_to", timeout[1], 0);
        check("ack_cleared_any", any_timeout, 0);
        check("ack_cleared_run", running[1], 0);
        ack[1] = 1'b0;

        // ch1 start coinciding with threshold hit
        thresh[1*W +: W] = 2;
        start[1] = 1'b1; step(); start[1] = 1'b0;
        check("sth_ct1", ctc(1), 1);
        step();
        check("sth_ct2", ctc(1), 2);
        start[1] = 1'b1; step(); start[1] = 1'b0;
        check("sth_restart_ct", ctc(1), 1);
        check("sth_no_pulse", timeout_pulse[1], 0);
        check("sth_no_expire", timeout[1], 0);
        step(); step();
        check("sth_later_expire", timeout[1], 1);
        check("sth_later_pulse", timeout_pulse[1], 1);

        // ch2 periodic with thresh 3
        exp_ct = '{1, 2, 3, 1, 2, 3, 1};
        exp_tp = '{0, 0, 0, 1, 0, 0, 1};
        thresh[2*W +: W] = 3; mode[2] = 1'b1;
        start[2] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(); start[2] = 1'b0;
            check($sformatf("per3_ct_%0d", k), ctc(2), exp_ct[k]);
            check($sformatf("per3_tp_%0d", k), timeout_pulse[2], exp_tp[k]);
        end
        check("per3_no_timeout", timeout[2], 0);

        // ch2 periodic with thresh 1
        thresh[2*W +: W] = 1;
        start[2] = 1'b1; step(); start[2] = 1'b0;
        check("per1_ct_a", ctc(2), 1);
        check("per1_tp_a", timeout_pulse[2], 0);
        step();
        check("per1_tp_b", timeout_pulse[2], 1);
        step();
        check("per1_ct_c", ctc(2), 1);
        check("per1_tp_c", timeout_pulse[2], 1);
        check("per1_running", running[2], 1);

        // 4-bit instance saturates without wrapping
        s4 = 1'b1; step(); s4 = 1'b0;
        check("w4_ct1", ct4, 1);
        repeat (12) step();
        step();
        check("w4_ct14", ct4, 14);
        check("w4_not_sat", sat4, 0);
        step();
        check("w4_ct15", ct4, 15);
        check("w4_sat", sat4, 1);
        repeat (3) step();
        check("w4_hold15", ct4, 15);
        check("w4_sat_hold", sat4, 1);
        check("w4_running", run4, 1);

        // ch3: start and ack edge in the same cycle, then a held ack
        start[3] = 1'b1; step(); start[3] = 1'b0;
        ack[3] = 1'b1;
        step();
        check("ch3_ctA", ctc(3), 2);
        step();
        start[3] = 1'b1; step(); start[3] = 1'b0;
        check("sa_ct", ctc(3), 1);
        check("sa_running", running[3], 1);
        step();
        check("sa_not_deferred", ctc(3), 2);
        repeat (3) step();
        check("held_ack_single", ctc(3), 5);
        ack[3] = 1'b0;
        repeat (3) step();
        ack[3] = 1'b1;
        repeat (3) step();
        check("reack_clear_ct", ctc(3), 0);
        check("reack_clear_run", running[3], 0);

        // asynchronous reset mid-activity
        #2 rst = 1'b1;
        #1;
        check("arst_ct_nonzero", {31'd0, ct != '0}, 0);
        check("arst_running", running, 0);
        check("arst_timeout", timeout, 0);
        check("arst_pulse", timeout_pulse, 0);
        check("arst_any", any_timeout, 0);
        check("arst_ct4", ct4, 0);
        check("arst_sat4", sat4, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", running, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
